// File: rtl/gsim_residual_check.sv
// Residual checker for the Gauss-Seidel solver: snoops b, captures x, streams r = b - A*x.
// Optional macro RESCHK_SAT_EN clamps each row residual to the signed Q16.16 range.
module gsim_residual_check #(
  parameter int          N   = 16,
  parameter logic [39:0] TOL = 40'h00_0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [15:0] b_in,
  input  logic        out_valid,
  input  logic [31:0] x_in,
  output logic [39:0] res_out,
  output logic        res_out_valid,
  output logic [39:0] res_max,
  output logic        pass,
  output logic        done,
  output logic        err
);

  // state    | meaning
  // S_IDLE   | waiting for first b sample
  // S_LOAD_B | snooping b[2..N]
  // S_WAIT_X | b complete, waiting for first x sample
  // S_LOAD_X | capturing x[2..N], one settle cycle after x[N]
  // S_CALC   | one matrix row per cycle
  // S_REPORT | final compare against TOL, pulse done
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_B, S_WAIT_X, S_LOAD_X, S_CALC, S_REPORT
  } state_t;

  localparam int             IW = $clog2(N);
  localparam int             CW = IW + 1;
  localparam logic [CW-1:0]  NC = CW'(N);
  localparam logic [CW-1:0]  NL = CW'(N - 1);

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic signed [39:0] r_b [N];
  logic signed [39:0] r_x [N];
  logic [39:0]        r_res_out, r_res_max;
  logic               r_res_valid, r_pass, r_done, r_err;

  logic               w_start, w_store_b, w_store_x, w_calc, w_report, w_err_set;
  logic signed [39:0] w_b_ext, w_x_ext, w_ax, w_r, w_rs;
  logic signed [39:0] w_t [7];
  logic [39:0]        w_abs;

  assign w_b_ext = {{8{b_in[15]}}, b_in, 16'h0000};
  assign w_x_ext = {{8{x_in[31]}}, x_in};

  function automatic logic signed [39:0] mul6(input logic signed [39:0] v);
    return (v <<< 2) + (v <<< 1);
  endfunction

  function automatic logic signed [39:0] mul13(input logic signed [39:0] v);
    return (v <<< 3) + (v <<< 2) + v;
  endfunction

  function automatic logic signed [39:0] mul20(input logic signed [39:0] v);
    return (v <<< 4) + (v <<< 2);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_store_b   = 1'b0;
    w_store_x   = 1'b0;
    w_calc      = 1'b0;
    w_report    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_en) begin
          w_start     = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_LOAD_B;
        end else if (out_valid) begin
          w_err_set = 1'b1;
        end
      end
      S_LOAD_B: begin
        if (out_valid) w_err_set = 1'b1;
        if (in_en) begin
          if (r_cnt < NC) begin
            w_store_b = 1'b1;
            w_cnt_nxt = r_cnt + CW'(1);
          end else begin
            w_err_set = 1'b1;
          end
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_cnt == NC) ? S_WAIT_X : S_IDLE;
        end
      end
      S_WAIT_X: begin
        if (in_en) begin
          w_start     = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_LOAD_B;
        end else if (out_valid) begin
          w_store_x   = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_LOAD_X;
        end
      end
      S_LOAD_X: begin
        if (in_en) begin
          w_start     = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_LOAD_B;
        end else if (r_cnt == NC) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_CALC;
        end else if (out_valid) begin
          w_store_x = 1'b1;
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_CALC: begin
        if (in_en) begin
          w_start     = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_LOAD_B;
        end else begin
          w_calc = 1'b1;
          if (r_cnt == NL) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_REPORT;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_REPORT: begin
        w_report    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Seven-tap window centred on the current row; taps outside 0..N-1 read as zero.
  always_comb begin : tap_sel
    int j;
    for (int d = 0; d < 7; d++) begin
      j      = int'(r_cnt) + d - 3;
      w_t[d] = '0;
      if (j >= 0 && j < N) w_t[d] = r_x[j[IW-1:0]];
    end
  end

  assign w_ax = mul20(w_t[3]) - mul13(w_t[2]) - mul13(w_t[4])
              + mul6(w_t[1]) + mul6(w_t[5]) - w_t[0] - w_t[6];
  assign w_r  = r_b[r_cnt[IW-1:0]] - w_ax;

`ifdef RESCHK_SAT_EN
  always_comb begin
    w_rs = w_r;
    if (w_r > 40'sh00_7FFF_FFFF)      w_rs = 40'sh00_7FFF_FFFF;
    else if (w_r < -40'sh00_8000_0000) w_rs = -40'sh00_8000_0000;
  end
`else
  assign w_rs = w_r;
`endif

  assign w_abs = w_rs[39] ? 40'(-w_rs) : 40'(w_rs);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_res_out   <= '0;
      r_res_max   <= '0;
      r_res_valid <= 1'b0;
      r_pass      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_b[i] <= '0;
        r_x[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_res_valid <= w_calc;
      r_done      <= w_report;
      if (w_start) begin
        r_b[0]    <= w_b_ext;
        r_err     <= 1'b0;
        r_pass    <= 1'b0;
        r_res_max <= '0;
      end
      if (w_store_b) r_b[r_cnt[IW-1:0]] <= w_b_ext;
      if (w_store_x) r_x[r_cnt[IW-1:0]] <= w_x_ext;
      if (w_err_set) r_err <= 1'b1;
      if (w_calc) begin
        r_res_out <= w_rs;
        if (w_abs > r_res_max) r_res_max <= w_abs;
      end
      if (w_report) r_pass <= (r_res_max <= TOL);
    end
  end

  assign res_out       = r_res_out;
  assign res_out_valid = r_res_valid;
  assign res_max       = r_res_max;
  assign pass          = r_pass;
  assign done          = r_done;
  assign err           = r_err;

endmodule
